// File: rtl/icache.sv
// Direct-mapped 16-line instruction cache with one-word lines and a single-request fill FSM.
// Optional define ICACHE_BYPASS_EN forwards the fill word to the datapath in the fill-complete cycle.
module icache #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        inval,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic [31:0] iload,
  input  logic        iwait
);

  // state | meaning
  // IDLE  | lookup; hits served combinationally, a miss latches its word address
  // FILL  | holding iREN for missaddr until memory drops iwait or inval aborts
  typedef enum logic {IDLE, FILL} state_t;

  state_t      state, next_state;
  logic [SETS-1:0] valid;
  logic [25:0] tag_arr  [SETS];
  logic [31:0] data_arr [SETS];
  logic [29:0] missaddr;

  logic [25:0] req_tag;
  logic [3:0]  req_idx;
  logic [3:0]  fill_idx;
  logic        hit_raw;
  logic        fill_done;
  logic        bypass;
  logic        latch_miss;
  logic        unused_offset;

  assign req_tag       = imemaddr[31:6];
  assign req_idx       = imemaddr[5:2];
  assign fill_idx      = missaddr[3:0];
  assign unused_offset = ^imemaddr[1:0];

  assign hit_raw   = imemREN & valid[req_idx] & (tag_arr[req_idx] == req_tag);
  assign fill_done = (state == FILL) & ~iwait & ~inval;

`ifdef ICACHE_BYPASS_EN
  assign bypass = fill_done & imemREN & (imemaddr[31:2] == missaddr);
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    next_state = state;
    ihit       = 1'b0;
    imemload   = 32'h0;
    iREN       = 1'b0;
    iaddr      = 32'h0;
    latch_miss = 1'b0;
    case (state)
      IDLE: begin
        // invalidate wins over both hit and miss so nothing is served from lines being cleared
        if (!inval) begin
          if (hit_raw) begin
            ihit     = 1'b1;
            imemload = data_arr[req_idx];
          end else if (imemREN) begin
            latch_miss = 1'b1;
            next_state = FILL;
          end
        end
      end
      FILL: begin
        iREN  = 1'b1;
        iaddr = {missaddr, 2'b00};
        if (inval || !iwait) next_state = IDLE;
        if (bypass) begin
          ihit     = 1'b1;
          imemload = iload;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      valid    <= '0;
      missaddr <= '0;
    end else begin
      state <= next_state;
      if (latch_miss) missaddr <= imemaddr[31:2];
      if (inval) valid <= '0;
      else if (fill_done) valid[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tag_arr[fill_idx]  <= missaddr[29:4];
      data_arr[fill_idx] <= iload;
    end
  end

endmodule
